exact_div_16x8: RTL

EXACT_DIV_16X8 -- requirements
Module: exact_div_16x8

---
 rtl/div_pkg.sv | 7 +
 rtl/div_step.sv | 20 ++
 rtl/exact_div_16x8.sv | 95 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared widths, default saturation quotient and FSM state type for the 16/8 divider
package div_pkg;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam logic [VW-1:0] SAT_Q_DEF = 8'hFF;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a dividend bit, trial-subtract, pick quotient bit)
module div_step
    import div_pkg::*;
(
    input  logic [VW:0]   rem_in,
    input  logic          dbit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          qbit
);
    logic [VW+1:0] shifted;
    logic [VW+1:0] diff;
    // The partial remainder stays below 512, so bit VW+1 of the 10-bit difference is a clean borrow flag
    always_comb begin
        shifted = {rem_in, dbit};
        diff    = shifted - {2'b00, divisor};
        qbit    = ~diff[VW+1];
        rem_out = qbit ? diff[VW:0] : shifted[VW:0];
    end
endmodule

// File: rtl/exact_div_16x8.sv
// exact_div_16x8: handshaked 16/8 unsigned restoring divider with overflow and divide-by-zero saturation
module exact_div_16x8
    import div_pkg::*;
#(
    parameter logic [VW-1:0] SAT_Q = SAT_Q_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          ovf,
    output logic          dz
);
    state_t        state;
    state_t        nxt;
    logic [2:0]    cnt;
    logic [VW:0]   rem;
    logic [VW-1:0] lo;
    logic [VW-1:0] dsr;
    logic          ovf_r;
    logic          dz_r;
    logic          accept;
    logic          dz_in;
    logic          ovf_in;
    logic [VW:0]   step_rem;
    logic          step_q;

    div_step u_step (
        .rem_in  (rem),
        .dbit    (lo[VW-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .qbit    (step_q)
    );

    // Classify the incoming operands: zero divisor, or a quotient that cannot fit in 8 bits
    always_comb begin
        accept = in_valid && (state == IDLE);
        dz_in  = (divisor == '0);
        ovf_in = !dz_in && (dividend[DW-1:VW] >= divisor);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state: special cases skip CALC, normal ops spend 8 cycles there
    always_comb begin
        nxt = state;
        if (accept)                              nxt = (dz_in || ovf_in) ? DONE : CALC;
        else if (state == CALC && cnt == 3'd0)   nxt = DONE;
        else if (state == DONE && out_ready)     nxt = IDLE;
    end

    // Datapath: lo holds remaining dividend bits and collects quotient bits as they shift in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 3'd0;
            rem   <= '0;
            lo    <= '0;
            dsr   <= '0;
            ovf_r <= 1'b0;
            dz_r  <= 1'b0;
        end else if (accept) begin
            cnt   <= 3'd7;
            dsr   <= divisor;
            dz_r  <= dz_in;
            ovf_r <= ovf_in;
            rem   <= dz_in ? {1'b0, dividend[VW-1:0]} : ovf_in ? '0 : {1'b0, dividend[DW-1:VW]};
            lo    <= (dz_in || ovf_in) ? SAT_Q : dividend[VW-1:0];
        end else if (state == CALC) begin
            cnt   <= cnt - 3'd1;
            rem   <= step_rem;
            lo    <= {lo[VW-2:0], step_q};
        end
    end

    // Handshake flags and result outputs, forced to zero outside DONE
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        quotient  = out_valid ? lo : '0;
        remainder = out_valid ? rem[VW-1:0] : '0;
        ovf       = out_valid && ovf_r;
        dz        = out_valid && dz_r;
    end
endmodule
